trig_time_tagger: RTL

- Downstream consumer of the combined trigger line, the OR of the two trigger sources.
- Time-stamps every rising edge of that line against a PPS-disciplined clock-cycle counter and a seconds counter.
- Measures the true clock cycles per PPS period.
- Presents one tagged event at a time to the readout/AXI register side through a valid/ack handshake.

---
 rtl/tt_pkg.sv | 15 +
 rtl/trig_time_tagger_if.sv | 26 ++
 rtl/pps_sync_edge.sv | 26 ++
 rtl/trig_time_tagger.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared widths, holding-register states and counter limits for the trigger time tagger
package tt_pkg;

    localparam int CNT_WIDTH  = 27;
    localparam int SEC_WIDTH  = 32;
    localparam int LOST_WIDTH = 16;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } tag_state_t;

endpackage

// File: rtl/trig_time_tagger_if.sv
// rtl/trig_time_tagger_if.sv - tagged-event valid/ack handshake towards the readout side
interface trig_time_tagger_if #(
    parameter int CNT_WIDTH = tt_pkg::CNT_WIDTH,
    parameter int SEC_WIDTH = tt_pkg::SEC_WIDTH
) ();

    logic                 evt_valid;
    logic                 evt_ack;
    logic [CNT_WIDTH-1:0] evt_cycles;
    logic [SEC_WIDTH-1:0] evt_second;

    modport master (
        output evt_valid,
        output evt_cycles,
        output evt_second,
        input  evt_ack
    );

    modport slave (
        input  evt_valid,
        input  evt_cycles,
        input  evt_second,
        output evt_ack
    );

endinterface

// File: rtl/pps_sync_edge.sv
// rtl/pps_sync_edge.sv - multi-flop synchronizer for an asynchronous timing input plus rising-edge pulse
module pps_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            sync_q <= 1'b0;
        end else begin
            sync   <= {sync[STAGES-2:0], async_in};
            sync_q <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~sync_q;

endmodule

// File: rtl/trig_time_tagger.sv
// rtl/trig_time_tagger.sv - tags trigger rising edges with PPS-disciplined cycle and second counts
module trig_time_tagger #(
    parameter int CNT_WIDTH       = tt_pkg::CNT_WIDTH,
    parameter int SEC_WIDTH       = tt_pkg::SEC_WIDTH,
    parameter int LOST_WIDTH      = tt_pkg::LOST_WIDTH,
    parameter int PPS_SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trig_in,
    input  logic                  pps_in,
    input  logic                  clear_lost,
    trig_time_tagger_if.master    evt,
    output logic [CNT_WIDTH-1:0]  pps_cycles,
    output logic                  pps_valid,
    output logic [SEC_WIDTH-1:0]  sec_count,
    output logic [LOST_WIDTH-1:0] lost_count,
    output logic                  pps_missing
);

    import tt_pkg::*;

    localparam logic [CNT_WIDTH-1:0]  CNT_TOP  = '1;
    localparam logic [LOST_WIDTH-1:0] LOST_TOP = '1;

    logic                 pps_edge;
    logic                 trig_q;
    logic                 trig_edge;
    logic [CNT_WIDTH-1:0] clk_count;
    logic [CNT_WIDTH-1:0] held_cycles;
    logic [SEC_WIDTH-1:0] held_second;
    tag_state_t           state;
    tag_state_t           state_n;
    logic                 load;
    logic                 drop;

    pps_sync_edge #(
        .STAGES (PPS_SYNC_STAGES)
    ) u_pps_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pps_in),
        .rise     (pps_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_in;
        end
    end

    assign trig_edge = trig_in & ~trig_q;

    // Counter saturates rather than wraps so a dead PPS shows up as a pinned count.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_count   <= '0;
            pps_cycles  <= '0;
            pps_valid   <= 1'b0;
            sec_count   <= '0;
            pps_missing <= 1'b0;
        end else begin
            pps_valid <= pps_edge;
            if (pps_edge) begin
                clk_count   <= '0;
                pps_cycles  <= clk_count + 1'b1;
                sec_count   <= sec_count + 1'b1;
                pps_missing <= 1'b0;
            end else if (clk_count == CNT_TOP) begin
                pps_missing <= 1'b1;
            end else begin
                clk_count <= clk_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        drop    = 1'b0;
        case (state)
            EMPTY: begin
                if (trig_edge) begin
                    load    = 1'b1;
                    state_n = FULL;
                end
            end
            FULL: begin
                if (trig_edge && evt.evt_ack) begin
                    load = 1'b1;
                end else if (trig_edge) begin
                    drop = 1'b1;
                end else if (evt.evt_ack) begin
                    state_n = EMPTY;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Tag uses pre-update counter values, so a coincident PPS leaves the event in the old second.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_cycles <= '0;
            held_second <= '0;
        end else if (load) begin
            held_cycles <= clk_count;
            held_second <= sec_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lost_count <= '0;
        end else if (clear_lost) begin
            lost_count <= {{(LOST_WIDTH-1){1'b0}}, drop};
        end else if (drop && (lost_count != LOST_TOP)) begin
            lost_count <= lost_count + 1'b1;
        end
    end

    assign evt.evt_valid  = (state == FULL);
    assign evt.evt_cycles = held_cycles;
    assign evt.evt_second = held_second;

endmodule
